// File: rtl/dmem_bytes.sv
// Byte-addressable RV32I data memory with byte-lane stores, sign/zero-extended loads and a clear-on-reset sweep.
// Latency: one cycle from request acceptance to response for both loads and stores.
// Backpressure: req_ready is low only during the clear sweep; the response side has no backpressure.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready handshake, with req_write, req_addr (byte address), req_size (RV32I funct3), req_wdata
//   rsp_valid, rsp_rdata (extended load data, 0 for stores and errors), rsp_err
//   busy (clear sweep in progress)
module dmem_bytes #(
    parameter int DEPTH          = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [31:0]     mem_q [DEPTH];

    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            out_of_range;
    logic            size_err;
    logic            req_err;
    logic            accept;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     ld_data;

    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [3:0]      wr_be;
    logic [31:0]     wr_dat;

    assign word_idx     = req_addr[AW+1:2];
    assign lane         = req_addr[1:0];
    // Any set bit above the word index means the word lies beyond DEPTH.
    assign out_of_range = |req_addr[31:AW+2];
    assign req_err      = size_err | out_of_range;
    assign accept       = req_valid && (state_q == ST_IDLE);

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CLEAR);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Size legality and alignment; unsigned sizes only make sense for loads.
    always_comb begin
        size_err = 1'b0;
        case (req_size)
            SZ_B:    size_err = 1'b0;
            SZ_H:    size_err = req_addr[0];
            SZ_W:    size_err = |req_addr[1:0];
            SZ_BU:   size_err = req_write;
            SZ_HU:   size_err = req_write | req_addr[0];
            default: size_err = 1'b1;
        endcase
    end

    // Load path: read the addressed word, pick the lane(s), extend.
    always_comb begin
        rd_word = mem_q[word_idx];
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = 32'd0;
        case (req_size)
            SZ_B:    ld_data = {{24{rd_byte[7]}}, rd_byte};
            SZ_H:    ld_data = {{16{rd_half[15]}}, rd_half};
            SZ_W:    ld_data = rd_word;
            SZ_BU:   ld_data = {24'd0, rd_byte};
            SZ_HU:   ld_data = {16'd0, rd_half};
            default: ld_data = 32'd0;
        endcase
    end

    // Write port: the sweep owns it in CLEAR, accepted clean stores own it in IDLE.
    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = word_idx;
        wr_be  = 4'b0000;
        wr_dat = req_wdata;
        if (state_q == ST_CLEAR) begin
            wr_en  = 1'b1;
            wr_idx = clr_idx_q;
            wr_be  = 4'b1111;
            wr_dat = 32'd0;
        end else begin
            wr_en = accept && req_write && !req_err;
            case (req_size)
                SZ_B: begin
                    wr_be  = 4'b0001 << lane;
                    wr_dat = {4{req_wdata[7:0]}};
                end
                SZ_H: begin
                    wr_be  = req_addr[1] ? 4'b1100 : 4'b0011;
                    wr_dat = {2{req_wdata[15:0]}};
                end
                SZ_W: begin
                    wr_be  = 4'b1111;
                    wr_dat = req_wdata;
                end
                default: begin
                    wr_be  = 4'b0000;
                    wr_dat = req_wdata;
                end
            endcase
        end
    end

    // Next-state for the sweep FSM and the response register.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            if (clr_idx_q == AW'(DEPTH - 1)) begin
                state_d   = ST_IDLE;
                clr_idx_d = '0;
            end else begin
                clr_idx_d = clr_idx_q + AW'(1);
            end
        end
        rsp_valid_d = accept;
        rsp_err_d   = accept && req_err;
        // Data is only meaningful for clean loads; everything else reads as zero.
        rsp_rdata_d = (accept && !req_write && !req_err) ? ld_data : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (CLEAR_ON_RESET) begin
                state_q <= ST_CLEAR;
            end else begin
                state_q <= ST_IDLE;
            end
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage has no reset: contents survive reset and are cleared only by the sweep.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_bytes.sv
// Self-checking bench for dmem_bytes: directed cases plus random traffic against a byte-array model.
// Inputs are driven and outputs sampled on the falling clock edge.
// The bench decides acceptance from its own notion of the sweep state, never from the DUT.
module tb_dmem_bytes;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  ref_mem [DEPTH*4];
    logic [31:0] last_rdata;

    logic        r_v, r_w;
    logic [31:0] r_a, r_d;
    logic [2:0]  r_s;
    int unsigned r_idx;

    always #5 clk = ~clk;

    dmem_bytes #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    endtask

    // Reference: memory is a flat byte array; an access touches n consecutive bytes.
    task automatic model(input logic w, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d, output logic [31:0] rd, output logic err);
        int n;
        logic [31:0] v;
        err = 1'b0;
        case (s)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default: begin n = 1; err = 1'b1; end
        endcase
        if ((a % 32'(n)) != 0) err = 1'b1;
        if ((a / 4) >= DEPTH) err = 1'b1;
        if (w && (s == 3'd4 || s == 3'd5)) err = 1'b1;
        rd = 32'd0;
        if (!err) begin
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8*i));
                if (s < 3'd4 && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                rd = v;
            end
        end
    endtask

    // One clock of traffic: present a request (or idle), then check the response one cycle later.
    task automatic step(input logic v, input logic w, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] d);
        logic [31:0] erd;
        logic        eerr;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        req_wdata = d;
        erd  = 32'd0;
        eerr = 1'b0;
        if (v) begin
            chk("req_ready", 32'(req_ready), 32'd1);
            model(w, a, s, d, erd, eerr);
        end
        @(negedge clk);
        chk($sformatf("rsp_valid a=%h s=%0d w=%0d", a, s, w), 32'(rsp_valid), 32'(v));
        chk($sformatf("rsp_err a=%h s=%0d w=%0d", a, s, w), 32'(rsp_err), 32'(eerr));
        chk($sformatf("rsp_rdata a=%h s=%0d w=%0d", a, s, w), rsp_rdata, erd);
        last_rdata = rsp_rdata;
        req_valid  = 1'b0;
    endtask

    // Called at the falling edge where reset is released: DEPTH busy cycles, then ready.
    // Requests offered during the sweep must be ignored.
    task automatic sweep_check();
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("sweep busy k=%0d", k), 32'(busy), 32'd1);
            chk($sformatf("sweep ready k=%0d", k), 32'(req_ready), 32'd0);
            chk($sformatf("sweep rsp_valid k=%0d", k), 32'(rsp_valid), 32'd0);
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 32'(k % DEPTH) << 2;
            req_size  = 3'd2;
            req_wdata = $urandom;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("sweep done ready", 32'(req_ready), 32'd1);
        chk("sweep done busy", 32'(busy), 32'd0);
        chk("sweep done rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_size  = 3'd0;
        req_wdata = 32'd0;
        last_rdata = 32'd0;
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset busy", 32'(busy), 32'd1);
        chk("reset ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_model();
        sweep_check();

        // Cleared memory reads as zero.
        step(1, 0, 32'h3C, 3'd2, 0);
        chk("lw 0x3c const", last_rdata, 32'd0);

        // Byte lanes.
        step(1, 1, 32'h8, 3'd2, 32'h1122_3344);
        step(1, 1, 32'h9, 3'd0, 32'h0000_00AA);
        step(1, 1, 32'hA, 3'd1, 32'h0000_BEEF);
        step(1, 0, 32'h8, 3'd2, 0);
        chk("lanes const", last_rdata, 32'hBEEF_AA44);

        // Extension.
        step(1, 1, 32'h4, 3'd2, 32'h80FF_7F80);
        step(1, 0, 32'h4, 3'd0, 0);
        chk("lb const", last_rdata, 32'hFFFF_FF80);
        step(1, 0, 32'h4, 3'd4, 0);
        chk("lbu const", last_rdata, 32'h0000_0080);
        step(1, 0, 32'h6, 3'd1, 0);
        chk("lh const", last_rdata, 32'hFFFF_80FF);
        step(1, 0, 32'h6, 3'd5, 0);
        chk("lhu const", last_rdata, 32'h0000_80FF);
        step(1, 0, 32'h7, 3'd4, 0);
        chk("lbu lane3 const", last_rdata, 32'h0000_0080);

        // Errors leave memory untouched.
        step(1, 0, 32'h2, 3'd2, 0);
        step(1, 1, 32'h5, 3'd1, 32'h1234_5678);
        step(1, 1, 32'(DEPTH*4), 3'd2, 32'hCAFE_F00D);
        step(1, 0, 32'h0, 3'd3, 0);
        step(1, 1, 32'h4, 3'd4, 32'h0000_0011);
        step(1, 1, 32'h8000_0004, 3'd2, 32'h5555_5555);
        step(1, 0, 32'h4, 3'd2, 0);
        chk("err unchanged const", last_rdata, 32'h80FF_7F80);

        // Back-to-back store then load.
        step(1, 1, 32'h0, 3'd2, 32'hDEAD_BEEF);
        step(1, 0, 32'h0, 3'd2, 0);
        chk("b2b const", last_rdata, 32'hDEAD_BEEF);
        step(0, 0, 32'h0, 3'd0, 0);

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            r_v   = ($urandom_range(0, 3) != 0);
            r_w   = 1'($urandom_range(0, 1));
            r_s   = 3'($urandom_range(0, 7));
            r_idx = $urandom_range(0, DEPTH);
            r_a   = (32'(r_idx) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) r_a[31] = 1'b1;
            r_d   = $urandom;
            step(r_v, r_w, r_a, r_s, r_d);
        end

        // Reset while a response is pending drops it immediately.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_size  = 3'd2;
        @(posedge clk);
        #1;
        chk("pending rsp_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("async rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async rsp_rdata", rsp_rdata, 32'd0);
        chk("async busy", 32'(busy), 32'd1);
        chk("async ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        sweep_check();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 32'(i) << 2, 3'd2, 0);

        // Reset in the middle of a sweep restarts it from word 0.
        step(1, 1, 32'h14, 3'd2, 32'h0BAD_CAFE);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midsweep rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midsweep busy", 32'(busy), 32'd1);
        chk("midsweep ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        sweep_check();
        step(1, 0, 32'h14, 3'd2, 0);
        chk("midsweep cleared const", last_rdata, 32'd0);
        step(1, 1, 32'h3C, 3'd1, 32'h0000_8001);
        step(1, 0, 32'h3E, 3'd1, 0);
        step(1, 0, 32'h3C, 3'd1, 0);
        chk("final lh const", last_rdata, 32'hFFFF_8001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
